// File: rtl/bitarray_flush_ctrl.sv
// bitarray_flush_ctrl: walks every set of the 4-way bit array, writes back dirty lines and cleans/invalidates them; `FLUSH_GANG_INVAL_EN` turns INVAL into one B_CMD_INVAL_ALL
module bitarray_flush_ctrl #(
  parameter int IDX_BITS = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  output logic                busy,
  output logic                done,
  output logic [IDX_BITS-1:0] index,
  output logic [3:0]          way_match,
  output logic                pe_read,
  output logic [3:0]          cmd,
  output logic                cmd_valid,
  input  logic [3:0]          val,
  input  logic [3:0]          mod,
  output logic                wb_req,
  output logic [IDX_BITS-1:0] wb_index,
  output logic [1:0]          wb_way,
  input  logic                wb_ack
);
  localparam logic [3:0] B_CMD_NOP       = 4'h0;
  localparam logic [3:0] B_CMD_INVAL     = 4'h2;
  localparam logic [3:0] B_CMD_CLEAN     = 4'h4;
  localparam logic [3:0] B_CMD_INVAL_ALL = 4'h8;
  localparam logic [1:0] OP_CLEAN = 2'b00;
  localparam logic [1:0] OP_FLUSH = 2'b01;
  localparam logic [1:0] OP_INVAL = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] SAMPLE = 3'd2;
  localparam logic [2:0] WB     = 3'd3;
  localparam logic [2:0] CMD    = 3'd4;
  localparam logic [2:0] HOLD   = 3'd5;
  localparam logic [2:0] NEXT   = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;
`ifdef FLUSH_GANG_INVAL_EN
  localparam bit GANG = 1'b1;
`else
  localparam bit GANG = 1'b0;
`endif

  logic [2:0]          state;
  logic [1:0]          op_q;
  logic [1:0]          way;
  logic                req;
  logic                step;
  logic [IDX_BITS-1:0] idx;
  logic [3:0]          vpend;
  logic [3:0]          mpend;
  logic                gang;
  logic                dirty;
  logic                more;
  logic [3:0]          mask;
  logic [3:0]          rest;
  logic [3:0]          cur_cmd;

  // lowest-numbered pending way
  function automatic logic [1:0] low(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction

  // per-way work decode: which command is due and whether another follows for the same way
  always_comb begin
    gang    = GANG && op_q == OP_INVAL;
    dirty   = mpend[way];
    more    = !gang && op_q != OP_CLEAN && dirty && !step;
    mask    = op_q == OP_CLEAN ? val & mod : val;
    rest    = vpend & ~(4'b0001 << way);
    cur_cmd = gang ? B_CMD_INVAL_ALL :
              op_q == OP_CLEAN ? B_CMD_CLEAN :
              op_q == OP_FLUSH ? (dirty && !step ? B_CMD_CLEAN : B_CMD_INVAL) :
              (step ? B_CMD_CLEAN : B_CMD_INVAL);
  end

  // array and write-back port outputs decoded from the state; all zero in IDLE so reset clears them at once
  always_comb begin
    busy      = req || (state != IDLE && state != DONE);
    done      = state == DONE;
    pe_read   = state == READ;
    cmd_valid = state == CMD;
    cmd       = cmd_valid ? cur_cmd : B_CMD_NOP;
    index     = idx;
    way_match = (state == CMD || state == HOLD) ? (gang ? 4'hf : 4'b0001 << way) : 4'h0;
    wb_req    = state == WB;
    wb_index  = wb_req ? idx : '0;
    wb_way    = wb_req ? way : 2'd0;
  end

  // walk FSM; an accepted start spends one busy cycle in IDLE so the top-level can hand over the array port before it is driven
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_CLEAN;
      way   <= 2'd0;
      req   <= 1'b0;
      step  <= 1'b0;
      idx   <= '0;
      vpend <= 4'h0;
      mpend <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            req   <= 1'b0;
            state <= gang ? CMD : READ;
          end else if (start) begin
            if (op == OP_RSVD) begin
              state <= DONE;
            end else begin
              req  <= 1'b1;
              op_q <= op;
              idx  <= '0;
              way  <= 2'd0;
              step <= 1'b0;
            end
          end
        end
        READ: state <= SAMPLE;
        SAMPLE: begin
          vpend <= mask;
          mpend <= mod;
          way   <= low(mask);
          step  <= 1'b0;
          state <= mask == 4'h0 ? NEXT : (op_q != OP_INVAL && mod[low(mask)]) ? WB : CMD;
        end
        WB: if (wb_ack) state <= CMD;
        CMD: state <= HOLD;
        HOLD: begin
          if (gang) begin
            state <= DONE;
          end else if (more) begin
            step  <= 1'b1;
            state <= CMD;
          end else begin
            vpend <= rest;
            way   <= low(rest);
            step  <= 1'b0;
            state <= rest == 4'h0 ? NEXT : (op_q != OP_INVAL && mpend[low(rest)]) ? WB : CMD;
          end
        end
        NEXT: begin
          if (idx == '1) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= READ;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitarray_flush_ctrl.sv
// tb_bitarray_flush_ctrl: random and directed walks checked against a rule-level model of the bit array and the expected command stream
module tb_bitarray_flush_ctrl;
  localparam int IB = 2;
  localparam int N  = 1 << IB;
  localparam logic [3:0] NOP       = 4'h0;
  localparam logic [3:0] INVAL     = 4'h2;
  localparam logic [3:0] CLEAN     = 4'h4;
  localparam logic [3:0] INVAL_ALL = 4'h8;
`ifdef FLUSH_GANG_INVAL_EN
  localparam bit GANG = 1'b1;
`else
  localparam bit GANG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          busy;
  logic          done;
  logic [IB-1:0] index;
  logic [3:0]    way_match;
  logic          pe_read;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [3:0]    val = 4'h0;
  logic [3:0]    mod = 4'h0;
  logic          wb_req;
  logic [IB-1:0] wb_index;
  logic [1:0]    wb_way;
  logic          wb_ack = 1'b0;

  bitarray_flush_ctrl #(.IDX_BITS(IB)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .busy(busy), .done(done),
    .index(index), .way_match(way_match), .pe_read(pe_read), .cmd(cmd), .cmd_valid(cmd_valid),
    .val(val), .mod(mod), .wb_req(wb_req), .wb_index(wb_index), .wb_way(wb_way), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int i, input logic [3:0] w, input logic [3:0] c);
    return {i[23:0], w, c};
  endfunction

  logic [3:0]    av[N];
  logic [3:0]    am[N];
  logic [31:0]   wb_log[$];
  logic [31:0]   cmd_log[$];
  int            ncyc = 0;
  int            done_cnt = 0;
  int            done_at = 0;
  int            busy_cnt = 0;
  int            rd_cnt = 0;
  int            wdly = 0;
  int            wcnt = 0;
  int            wb_cost = 0;
  bit            ack_en = 1'b1;
  logic          rd_q = 1'b0;
  logic [IB-1:0] rd_idx = '0;

  always @(posedge clk) ncyc <= ncyc + 1;

  // bit array model, write-back acceptor and event logger, all on the falling edge
  always @(negedge clk) begin
    if (rd_q) begin
      val = av[rd_idx];
      mod = am[rd_idx];
    end else begin
      val = 4'($urandom);
      mod = 4'($urandom);
    end
    rd_q   = pe_read;
    rd_idx = index;
    if (pe_read) rd_cnt++;
    check("cmd_valid_vs_cmd", 32'(cmd_valid), 32'(cmd != NOP));
    check("read_with_cmd", 32'(pe_read && cmd_valid), 32'(0));
    check("way_match_idle", 32'(!busy && way_match != 4'h0), 32'(0));
    if (cmd_valid) begin
      cmd_log.push_back(mk(int'(index), way_match, cmd));
      if (cmd == CLEAN) am[index] = am[index] & ~way_match;
      if (cmd == INVAL) av[index] = av[index] & ~way_match;
      if (cmd == INVAL_ALL) for (int i = 0; i < N; i++) av[i] = 4'h0;
    end
    if (wb_ack) begin
      wb_ack = 1'b0;
      wcnt   = 0;
      wdly   = $urandom_range(0, 3);
    end else if (wb_req && ack_en) begin
      if (wcnt == wdly) wb_ack = 1'b1;
      else wcnt++;
    end else begin
      wcnt = 0;
    end
    if (wb_req && wb_ack) begin
      wb_log.push_back(mk(int'(wb_index), 4'b0001 << wb_way, NOP));
      wb_cost += wdly + 1;
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_at = ncyc;
    end
  end

  // one complete operation from a start pulse, compared with the rule-level expectation
  task automatic run(input logic [1:0] o, input bit poke, input string tag);
    logic [3:0]  ev[N];
    logic [3:0]  em[N];
    logic [31:0] xwb[$];
    logic [31:0] xcmd[$];
    logic [3:0]  work;
    logic [3:0]  wm;
    int          base;
    int          t0;
    for (int i = 0; i < N; i++) begin
      ev[i] = av[i];
      em[i] = am[i];
    end
    if (o == 2'b11) begin
      base = 1;
    end else if (GANG && o == 2'b10) begin
      base = 4;
      xcmd.push_back(mk(0, 4'hf, INVAL_ALL));
      for (int i = 0; i < N; i++) ev[i] = 4'h0;
    end else begin
      for (int i = 0; i < N; i++) begin
        work = o == 2'b00 ? av[i] & am[i] : av[i];
        for (int w = 0; w < 4; w++) begin
          if (work[w]) begin
            wm = 4'b0001 << w;
            if (o != 2'b10 && am[i][w]) xwb.push_back(mk(i, wm, NOP));
            if (o == 2'b00) xcmd.push_back(mk(i, wm, CLEAN));
            else if (o == 2'b01) begin
              if (am[i][w]) xcmd.push_back(mk(i, wm, CLEAN));
              xcmd.push_back(mk(i, wm, INVAL));
            end else begin
              xcmd.push_back(mk(i, wm, INVAL));
              if (am[i][w]) xcmd.push_back(mk(i, wm, CLEAN));
            end
          end
        end
        em[i] = am[i] & ~av[i];
        ev[i] = o == 2'b00 ? av[i] : 4'h0;
      end
      base = 2 + 3 * N + 2 * xcmd.size();
    end
    @(negedge clk);
    wb_log.delete();
    cmd_log.delete();
    wb_cost  = 0;
    busy_cnt = 0;
    done_cnt = 0;
    rd_cnt   = 0;
    start    = 1'b1;
    op       = o;
    t0       = ncyc;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      @(negedge clk);
      start = poke && k == 5;
      if (start) op = 2'(o + 2'd1);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(done_cnt), 32'(1));
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, 32'(done_cnt), 32'(1));
    check({tag, "_done_cycle"}, 32'(done_at - t0), 32'(base + wb_cost));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(base + wb_cost - 1));
    if (o == 2'b11 || (GANG && o == 2'b10)) check({tag, "_reads"}, 32'(rd_cnt), 32'(0));
    check({tag, "_wb_count"}, 32'(wb_log.size()), 32'(xwb.size()));
    for (int i = 0; i < xwb.size() && i < wb_log.size(); i++) check({tag, "_wb"}, wb_log[i], xwb[i]);
    check({tag, "_cmd_count"}, 32'(cmd_log.size()), 32'(xcmd.size()));
    for (int i = 0; i < xcmd.size() && i < cmd_log.size(); i++) check({tag, "_cmd"}, cmd_log[i], xcmd[i]);
    for (int i = 0; i < N; i++) check({tag, "_array"}, 32'({av[i], am[i]}), 32'({ev[i], em[i]}));
  endtask

  task automatic clear_array();
    for (int i = 0; i < N; i++) begin
      av[i] = 4'h0;
      am[i] = 4'h0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_pe_read"}, 32'(pe_read), 32'(0));
    check({tag, "_cmd"}, 32'(cmd), 32'(NOP));
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'(0));
    check({tag, "_index"}, 32'(index), 32'(0));
    check({tag, "_way_match"}, 32'(way_match), 32'(0));
    check({tag, "_wb_req"}, 32'(wb_req), 32'(0));
    check({tag, "_wb_index"}, 32'(wb_index), 32'(0));
    check({tag, "_wb_way"}, 32'(wb_way), 32'(0));
  endtask

  initial begin
    clear_array();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run(2'b01, 1'b0, "empty_flush");
    clear_array();
    av[2] = 4'b0010;
    am[2] = 4'b0010;
    run(2'b01, 1'b0, "single_dirty");
    clear_array();
    av[0] = 4'b1111;
    am[0] = 4'b1010;
    run(2'b00, 1'b0, "clean_mixed");
    clear_array();
    av[1] = 4'b0101;
    am[1] = 4'b0100;
    run(2'b10, 1'b0, "inval");
    run(2'b11, 1'b0, "reserved");
    for (int i = 0; i < N; i++) begin
      av[i] = 4'($urandom);
      am[i] = 4'($urandom);
    end
    run(2'b01, 1'b1, "ignored_start");
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        av[i] = 4'($urandom);
        am[i] = 4'($urandom);
      end
      run(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
    end
    clear_array();
    av[1] = 4'b0100;
    am[1] = 4'b0100;
    av[3] = 4'b1001;
    am[3] = 4'b0001;
    ack_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && !wb_req; k++) @(negedge clk);
    check("midwalk_wb_req", 32'(wb_req), 32'(1));
    reset = 1'b1;
    #1;
    check_reset_outputs("midwalk_reset");
    done_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (5) @(negedge clk);
    check("midwalk_no_done", 32'(done_cnt), 32'(0));
    run(2'b01, 1'b0, "after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitarray_flush_ctrl.md
# bitarray_flush_ctrl

Maintenance initiator for the 4-way valid/modified/LRU bit array. On a single start pulse it walks every set index, reads the valid and modified bits, requests write-back of dirty lines, and issues the per-way bit commands that clean and/or invalidate them. It sits between the cache top-level control (flush/invalidate requests) and the bit array command port. It drives the same index/way_match/pe_read/cmd lines that the lookup path drives. The top-level muxes ownership to this block while `busy`=1.

## Interface
- `IDX_BITS`, 13, set-index width; entries = 2**IDX_BITS. Way count is fixed at 4.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request pulse, sampled only in IDLE.
- `op` in 2: operation, sampled with `start`.
  - 00 CLEAN: write back dirty lines, keep them valid.
  - 01 FLUSH: write back dirty lines, then invalidate.
  - 10 INVAL: discard all lines, no write-back.
  - 11: reserved.
- `busy` out 1: the walk is in progress.
- `done` out 1: one-cycle completion pulse.
- `index` out IDX_BITS: bit array set index.
- `way_match` out 4: one-hot target way for commands.
- `pe_read` out 1: bit array read strobe.
- `cmd` out 4: bit command, using encodings from the shared bit command include.
- `cmd_valid` out 1: `cmd` is not NOP.
- `val` in 4: valid bits, registered by the array one cycle after `pe_read`.
- `mod` in 4: modified bits, with the same timing as `val`.
- `wb_req` out 1: write-back request, level; held until acknowledged.
- `wb_index` out IDX_BITS: set of the line to write back.
- `wb_way` out 2: way of the line to write back.
- `wb_ack` in 1: write-back accepted; may arrive in the same cycle `wb_req` rises.

## Operation
States: IDLE, READ, SAMPLE, WB, CMD, HOLD, NEXT, DONE.

Per-state behaviour:
- **IDLE**: `start`=1 with `op`≠11 latches `op`, clears the index counter and goes to READ. `start` with `op`=11 goes straight to DONE with no array activity. `start` in any other state is ignored.
- **READ**: drives `index` and `pe_read`=1.
- **SAMPLE**: captures `val`/`mod` into `vpend`/`mpend`.
  - Work mask per op: CLEAN = `val&mod`; FLUSH and INVAL = `val`.
  - Empty mask goes to NEXT; otherwise select the lowest-numbered pending way.
- **Per selected way** (CLEAN/FLUSH):
  - Way dirty: go to WB first.
  - CLEAN issues B_CMD_CLEAN only.
  - FLUSH issues B_CMD_CLEAN if the way was dirty, then B_CMD_INVAL.
- **Per selected way** (INVAL): issue B_CMD_INVAL, then B_CMD_CLEAN if the way was dirty. No WB.
- **WB**: `wb_req`=1 with `wb_index`=index and `wb_way`=way. Leaves on the cycle `wb_ack`=1.
- **CMD**: `cmd`=command, `cmd_valid`=1, `index` and `way_match` driven.
- **HOLD**: `cmd`=NOP, with `index` and `way_match` held unchanged (the array applies the write one cycle after the command). Afterwards: the next command for the same way, else the next pending way, else NEXT.
- **NEXT**: if index = 2**IDX_BITS−1, go to DONE; else increment the index and go to READ.
- **DONE**: `done`=1 for one cycle, `busy`=0, then IDLE.

Array-side rules:
- Only B_CMD_CLEAN, B_CMD_INVAL (and B_CMD_INVAL_ALL under the macro) are issued. LRU state is never modified.
- `cmd`=NOP and `cmd_valid`=0 in every state other than CMD.
- `pe_read`=1 only in READ.
- `way_match`=0 outside CMD/HOLD.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `pe_read`=0, `cmd`=NOP, `cmd_valid`=0, `index`=0, `way_match`=0, `wb_req`=0, `wb_index`=0, `wb_way`=0.
- `busy` rises the cycle after `start`. It is high in READ through NEXT and low in DONE.
- Cycle costs:
  - Index with no work: 3 cycles (READ, SAMPLE, NEXT).
  - Each command: 2 cycles.
  - Each write-back: 1 + (cycles until `wb_ack`).
- Empty array with IDX_BITS=2: `start` at cycle 0 → `done` at cycle 14.
- Index counter wrap: the final index is detected explicitly. The counter never wraps to 0 and restarts.
- Reset mid-walk: everything returns to reset values immediately. A pending `wb_req` is dropped. No `done` pulse is produced.

## Configuration
- `FLUSH_GANG_INVAL_EN` defined:
  - `op`=INVAL issues a single B_CMD_INVAL_ALL: one CMD cycle, one HOLD cycle, then DONE.
  - `start` at cycle 0 gives `done` at cycle 4, independent of IDX_BITS.
  - Mod bits are not cleared in this mode.
- `FLUSH_GANG_INVAL_EN` undefined: `op`=INVAL performs the full per-index walk described above.
- CLEAN and FLUSH are identical in both builds.

## Test plan
- **Empty array**: IDX_BITS=2, all bits 0, FLUSH → no `wb_req`, no `cmd_valid`, `done` at cycle 14, `busy` high for cycles 1–13.
- **Single dirty line**: index 2, way 1, val=0010, mod=0010, FLUSH, `wb_ack` 3 cycles after `wb_req` → one write-back {2,1}, then CLEAN then INVAL with way_match=0010. Afterwards val[2]=0000, mod[2]=0000, LRU unchanged.
- **CLEAN of mixed set**: index 0, val=1111, mod=1010 → write-backs for ways 1 then 3, two B_CMD_CLEAN, val stays 1111, mod becomes 0000.
- **INVAL without the macro**: val=0101, mod=0100 at index 1 → no `wb_req`; commands INVAL w0, INVAL w2, CLEAN w2. With the macro: a single B_CMD_INVAL_ALL and `done` at cycle 4.
- **Reset mid-walk**: assert `reset` while `wb_req`=1 → all outputs at reset values the same cycle, no `done`. A following `start` runs a full walk from index 0.
- **Reserved op and ignored start**: `op`=11 → `done` after 1 cycle with no array activity. `start` pulsed while busy → ignored, exactly one `done`.
